// File: rtl/pck_rd_sched.sv
// Read-side scheduler: pops one byte length per packet, then issues ceil(len/BYTES_PER_WORD) data reads tagged sop/eop/be.
// Beats are registered one cycle after data_rd_en; optional statistics counters are enabled with `define PCK_RD_SCHED_STATS_EN.
module pck_rd_sched #(
  parameter int LEN_WIDTH      = 12,
  parameter int BYTES_PER_WORD = 4,
  parameter int MAX_LEN        = 2048,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                      clk,
  input  logic                      hw_rst,
  input  logic                      sw_rst,
  input  logic                      sched_en,
  input  logic                      len_empty,
  output logic                      len_rd_en,
  input  logic [LEN_WIDTH-1:0]      len_data,
  input  logic                      data_empty,
  output logic                      data_rd_en,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [BYTES_PER_WORD-1:0] out_be,
  output logic                      busy,
  output logic                      err_len,
  output logic                      pkt_done
`ifdef PCK_RD_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_pkt_cnt,
  output logic [31:0]               stat_byte_cnt,
  output logic [15:0]               stat_err_cnt
`endif
);

  localparam int SHIFT = $clog2(BYTES_PER_WORD);
  localparam int REM_W = (SHIFT > 0) ? SHIFT : 1;
  localparam int CNT_W = LEN_WIDTH + 1;
  localparam int GAP_W = 4;

  typedef enum logic [2:0] {IDLE, POP, LEN, XFER, GAP} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic                      first_q, first_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_sop_q, out_sop_d;
  logic                      out_eop_q, out_eop_d;
  logic [BYTES_PER_WORD-1:0] out_be_q, out_be_d;

  logic [CNT_W-1:0]          len_ext;
  logic [CNT_W-1:0]          words;
  logic                      len_bad;
  logic [REM_W-1:0]          len_rem;
  logic [BYTES_PER_WORD-1:0] eop_be;

  always_comb begin
    len_ext = {1'b0, len_data};
    len_bad = (len_data == '0) || (len_ext > CNT_W'(MAX_LEN));
    words   = (len_ext + CNT_W'(BYTES_PER_WORD - 1)) >> SHIFT;
    len_rem = (SHIFT > 0) ? len_q[REM_W-1:0] : '0;
    // A zero remainder means the last word is completely filled.
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      eop_be[i] = (len_rem == '0) || (i < int'(len_rem));
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    len_d       = len_q;
    first_d     = first_q;
    gap_d       = gap_q;
    len_rd_en   = 1'b0;
    data_rd_en  = 1'b0;
    err_len     = 1'b0;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_be_d    = '0;
    case (state_q)
      IDLE: begin
        if (sched_en && !len_empty) state_d = POP;
      end
      POP: begin
        len_rd_en = 1'b1;
        state_d   = LEN;
      end
      LEN: begin
        len_d   = len_data;
        first_d = 1'b1;
        gap_d   = '0;
        if (len_bad) begin
          err_len = 1'b1;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          rem_d   = words;
          state_d = XFER;
        end
      end
      XFER: begin
        data_rd_en = out_ready & ~data_empty;
        if (data_rd_en) begin
          rem_d       = rem_q - CNT_W'(1);
          first_d     = 1'b0;
          out_valid_d = 1'b1;
          out_sop_d   = first_q;
          if (rem_q == CNT_W'(1)) begin
            out_eop_d = 1'b1;
            out_be_d  = eop_be;
            state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            out_be_d = '1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Software reset wins over everything, including this cycle's strobes.
    if (sw_rst) begin
      state_d     = IDLE;
      rem_d       = '0;
      len_d       = '0;
      first_d     = 1'b0;
      gap_d       = '0;
      len_rd_en   = 1'b0;
      data_rd_en  = 1'b0;
      err_len     = 1'b0;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      out_be_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge hw_rst) begin
    if (!hw_rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      len_q       <= '0;
      first_q     <= 1'b0;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      first_q     <= first_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_be_q    <= out_be_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_be    = out_be_q;
  assign pkt_done  = out_eop_q;
  assign busy      = (state_q != IDLE);

`ifdef PCK_RD_SCHED_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [32:0] byte_sum;

  // len_q still holds the finishing packet's length when pkt_done fires.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    err_cnt_d  = err_cnt_q;
    byte_sum   = {1'b0, byte_cnt_q} + 33'(len_q);
    if (pkt_done) begin
      if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 32'd1;
      byte_cnt_d = byte_sum[32] ? '1 : byte_sum[31:0];
    end
    if (err_len && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
    if (sw_rst) begin
      pkt_cnt_d  = '0;
      byte_cnt_d = '0;
      err_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge hw_rst) begin
    if (!hw_rst) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_byte_cnt = byte_cnt_q;
  assign stat_err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_pck_rd_sched.sv
// Bench for pck_rd_sched: a length-FIFO stand-in, a packet-level beat model and per-scenario tasks.
module tb_pck_rd_sched;
  localparam int LW   = 12;
  localparam int BPW  = 4;
  localparam int MAXL = 2048;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic hw_rst = 1'b0, sw_rst = 1'b0, sched_en = 1'b0, len_empty = 1'b1;
  logic len_rd_en, data_rd_en, out_valid, out_sop, out_eop, busy, err_len, pkt_done;
  logic [LW-1:0] len_data = '0;
  logic data_empty = 1'b0, out_ready = 1'b1;
  logic [BPW-1:0] out_be;
`ifdef PCK_RD_SCHED_STATS_EN
  logic [31:0] stat_pkt_cnt, stat_byte_cnt;
  logic [15:0] stat_err_cnt;
`endif

  pck_rd_sched #(.LEN_WIDTH(LW), .BYTES_PER_WORD(BPW), .MAX_LEN(MAXL), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .hw_rst(hw_rst), .sw_rst(sw_rst), .sched_en(sched_en),
    .len_empty(len_empty), .len_rd_en(len_rd_en), .len_data(len_data),
    .data_empty(data_empty), .data_rd_en(data_rd_en), .out_ready(out_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_be(out_be),
    .busy(busy), .err_len(err_len), .pkt_done(pkt_done)
`ifdef PCK_RD_SCHED_STATS_EN
    , .stat_pkt_cnt(stat_pkt_cnt), .stat_byte_cnt(stat_byte_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  int checks = 0, failures = 0;
  int len_list[$];
  logic [5:0] exp_q[$], obs_q[$];
  int pop_gap_q[$], rd_gap_q[$];
  int exp_err = 0, exp_done = 0;
  int len_pops = 0, rd_cnt = 0, err_cnt = 0, done_cnt = 0, inv_err = 0, ncyc = 0;
  int last_eop_cyc = -1;
  bit pend_first = 1'b0;
  int ready_mode = 0, empty_start = -100;
  bit empty_rand = 1'b0;

  // Monitor: samples on the falling edge, mid-cycle, and plays the length FIFO.
  always @(negedge clk) begin
    ncyc++;
    if (len_rd_en && data_rd_en) inv_err++;
    if (data_rd_en && (data_empty || !out_ready)) inv_err++;
    if (pkt_done !== out_eop) inv_err++;
    if (len_rd_en) begin
      if (last_eop_cyc >= 0) pop_gap_q.push_back(ncyc - last_eop_cyc);
      len_data = (len_pops < len_list.size()) ? LW'(len_list[len_pops]) : '0;
      len_pops++;
      pend_first = 1'b1;
    end
    if (data_rd_en) begin
      rd_cnt++;
      if (pend_first && last_eop_cyc >= 0) rd_gap_q.push_back(ncyc - last_eop_cyc);
      pend_first = 1'b0;
    end
    if (out_valid) begin
      obs_q.push_back({out_sop, out_eop, out_be});
      if (out_eop) last_eop_cyc = ncyc;
    end
    if (err_len) err_cnt++;
    if (pkt_done) done_cnt++;
  end

  // Driver: inputs change just after the rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = ~out_ready;
    endcase
    data_empty = (ncyc >= empty_start && ncyc < empty_start + 2) ||
                 (empty_rand && $urandom_range(0, 4) == 0);
    len_empty  = (len_pops >= len_list.size());
  end

  // Packet-level model: a legal length yields ceil(len/4) beats, the last carrying len%4 enables.
  task automatic push_pkt(input int len);
    int w, r;
    logic [3:0] lbe;
    len_list.push_back(len);
    if (len == 0 || len > MAXL) begin
      exp_err++;
    end else begin
      w   = (len + BPW - 1) / BPW;
      r   = len % BPW;
      lbe = (r == 0) ? 4'hF : 4'((1 << r) - 1);
      for (int i = 0; i < w; i++)
        exp_q.push_back({(i == 0), (i == w - 1), (i == w - 1) ? lbe : 4'hF});
      exp_done++;
    end
  endtask

  function automatic int beat_diffs();
    int n, m;
    n = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (obs_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic wait_idle(output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk); #1;
      if (len_pops >= len_list.size() && !busy && !out_valid) quiet++;
      else quiet = 0;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_reads(input int target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (rd_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    repeat (3) @(negedge clk);
    #1;
    outs = {len_rd_en, data_rd_en, out_valid, out_sop, out_eop, out_be, busy, err_len, pkt_done};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    @(posedge clk); #1 hw_rst = 1'b1; sched_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int r0, o0, d0;
    bit ok;
    r0 = rd_cnt; o0 = obs_q.size(); d0 = done_cnt;
    push_pkt(10);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: got busy expected idle"); end
    checks++;
    if (rd_cnt - r0 !== 3) begin failures++; $display("FAIL basic_reads: got %0d expected 3", rd_cnt - r0); end
    checks++;
    if (obs_q[o0+2] !== 6'b01_0011) begin failures++; $display("FAIL basic_eop_beat: got %b expected 010011", obs_q[o0+2]); end
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_pkt_done: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (beat_diffs() !== 0) begin failures++; $display("FAIL basic_beats: got %0d diffs expected 0", beat_diffs()); end
  endtask

  task automatic test_single_word();
    int o0;
    bit ok;
    o0 = obs_q.size();
    push_pkt(4);
    push_pkt(5);
    wait_idle(ok);
    checks++;
    if (obs_q[o0] !== 6'b11_1111) begin failures++; $display("FAIL single_beat: got %b expected 111111", obs_q[o0]); end
    checks++;
    if (pop_gap_q[$] !== GAP + 1) begin failures++; $display("FAIL single_gap_to_pop: got %0d expected %0d", pop_gap_q[$], GAP + 1); end
    checks++;
    if (beat_diffs() !== 0 || !ok) begin failures++; $display("FAIL single_beats: got %0d diffs ok=%0b expected 0", beat_diffs(), ok); end
  endtask

  task automatic test_len_errors();
    int e0, r0;
    bit ok;
    e0 = err_cnt; r0 = rd_cnt;
    push_pkt(0);
    push_pkt(3000);
    wait_idle(ok);
    checks++;
    if (err_cnt - e0 !== 2) begin failures++; $display("FAIL err_pulses: got %0d expected 2", err_cnt - e0); end
    checks++;
    if (rd_cnt - r0 !== 0) begin failures++; $display("FAIL err_no_reads: got %0d expected 0", rd_cnt - r0); end
    checks++;
    if (!ok || busy !== 1'b0) begin failures++; $display("FAIL err_back_to_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_stall();
    int r0, o0;
    bit ok;
    r0 = rd_cnt; o0 = obs_q.size();
    ready_mode = 2;
    push_pkt(16);
    wait_reads(r0 + 1, ok);
    empty_start = ncyc;
    wait_idle(ok);
    ready_mode = 0;
    checks++;
    if (rd_cnt - r0 !== 4) begin failures++; $display("FAIL stall_reads: got %0d expected 4", rd_cnt - r0); end
    checks++;
    if (inv_err !== 0) begin failures++; $display("FAIL stall_invariants: got %0d violations expected 0", inv_err); end
    checks++;
    if (beat_diffs() !== 0 || obs_q.size() - o0 !== 4) begin failures++; $display("FAIL stall_beats: got %0d diffs expected 0", beat_diffs()); end
  endtask

  task automatic test_sw_rst();
    int r0, o0, d0;
    bit ok;
    logic [12:0] outs;
    r0 = rd_cnt; o0 = obs_q.size(); d0 = done_cnt;
    push_pkt(20);
    wait_reads(r0 + 2, ok);
    @(posedge clk); #1 sw_rst = 1'b1;
    @(posedge clk); #1 sw_rst = 1'b0;
    while (len_list.size() > len_pops) len_list.pop_back();
    outs = {len_rd_en, data_rd_en, out_valid, out_sop, out_eop, out_be, busy, err_len, pkt_done};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL swrst_outputs: got %h expected 0", outs); end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() - o0 !== 2 || done_cnt !== d0) begin
      failures++; $display("FAIL swrst_abandon: got beats=%0d done=%0d expected 2,0", obs_q.size() - o0, done_cnt - d0);
    end
    while (exp_q.size() > obs_q.size()) exp_q.pop_back();
    exp_done--;
    r0 = rd_cnt;
    push_pkt(8);
    wait_idle(ok);
    checks++;
    if (rd_cnt - r0 !== 2 || beat_diffs() !== 0) begin
      failures++; $display("FAIL swrst_recover: got reads=%0d diffs=%0d expected 2,0", rd_cnt - r0, beat_diffs());
    end
  endtask

  task automatic test_sched_en_drop();
    int r0, d0, p0;
    bit ok;
    r0 = rd_cnt; d0 = done_cnt; p0 = len_pops;
    push_pkt(12);
    push_pkt(8);
    wait_reads(r0 + 1, ok);
    sched_en = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (done_cnt - d0 !== 1 || len_pops - p0 !== 1) begin
      failures++; $display("FAIL sched_drop: got done=%0d pops=%0d expected 1,1", done_cnt - d0, len_pops - p0);
    end
    sched_en = 1'b1;
    wait_idle(ok);
    checks++;
    if (done_cnt - d0 !== 2 || beat_diffs() !== 0) begin
      failures++; $display("FAIL sched_resume: got done=%0d diffs=%0d expected 2,0", done_cnt - d0, beat_diffs());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    push_pkt(8); push_pkt(4); push_pkt(12); push_pkt(1);
    wait_idle(ok);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (rd_gap_q[rd_gap_q.size() - i] !== GAP + 3) begin
        failures++; $display("FAIL b2b_eop_to_read: got %0d expected %0d", rd_gap_q[rd_gap_q.size() - i], GAP + 3);
      end
      checks++;
      if (pop_gap_q[pop_gap_q.size() - i] !== GAP + 1) begin
        failures++; $display("FAIL b2b_eop_to_pop: got %0d expected %0d", pop_gap_q[pop_gap_q.size() - i], GAP + 1);
      end
    end
    checks++;
    if (beat_diffs() !== 0) begin failures++; $display("FAIL b2b_beats: got %0d diffs expected 0", beat_diffs()); end
  endtask

  task automatic test_random();
    int e0, d0, ee0, ed0, len;
    bit ok;
    e0 = err_cnt; d0 = done_cnt; ee0 = exp_err; ed0 = exp_done;
    ready_mode = 1; empty_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 9))
        0:       len = $urandom_range(MAXL + 1, 4095);
        1:       len = 0;
        2:       len = MAXL;
        default: len = $urandom_range(1, 64);
      endcase
      push_pkt(len);
    end
    wait_idle(ok);
    ready_mode = 0; empty_rand = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL rand_timeout: got busy expected idle"); end
    checks++;
    if (beat_diffs() !== 0) begin failures++; $display("FAIL rand_beats: got %0d diffs expected 0", beat_diffs()); end
    checks++;
    if (err_cnt - e0 !== exp_err - ee0 || done_cnt - d0 !== exp_done - ed0) begin
      failures++; $display("FAIL rand_counts: got err=%0d done=%0d expected %0d,%0d",
                           err_cnt - e0, done_cnt - d0, exp_err - ee0, exp_done - ed0);
    end
    checks++;
    if (inv_err !== 0) begin failures++; $display("FAIL rand_invariants: got %0d expected 0", inv_err); end
  endtask

  task automatic test_hw_rst();
    int r0, o0, rr;
    bit ok;
    logic [12:0] outs;
    r0 = rd_cnt; o0 = obs_q.size();
    push_pkt(40);
    wait_reads(r0 + 2, ok);
    @(posedge clk); #3 hw_rst = 1'b0;
    #1;
    rr = rd_cnt - r0;
    outs = {len_rd_en, data_rd_en, out_valid, out_sop, out_eop, out_be, busy, err_len, pkt_done};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL hwrst_async_outputs: got %h expected 0", outs); end
    while (len_list.size() > len_pops) len_list.pop_back();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() - o0 !== rr - 1) begin
      failures++; $display("FAIL hwrst_beats: got %0d expected %0d", obs_q.size() - o0, rr - 1);
    end
`ifdef PCK_RD_SCHED_STATS_EN
    checks++;
    if (stat_pkt_cnt !== 0 || stat_byte_cnt !== 0 || stat_err_cnt !== 0) begin
      failures++; $display("FAIL hwrst_stats: got %0d,%0d,%0d expected 0,0,0", stat_pkt_cnt, stat_byte_cnt, stat_err_cnt);
    end
`endif
    while (exp_q.size() > obs_q.size()) exp_q.pop_back();
    @(posedge clk); #1 hw_rst = 1'b1;
    push_pkt(8);
    wait_idle(ok);
    checks++;
    if (beat_diffs() !== 0 || !ok) begin failures++; $display("FAIL hwrst_recover: got %0d diffs expected 0", beat_diffs()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_word();
    test_len_errors();
    test_stall();
    test_sw_rst();
    test_sched_en_drop();
    test_back_to_back();
    test_random();
    test_hw_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
